// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - font constants, blank pattern and FSM state type for the seg7 scan decoder
package seg7_pkg;

   // Active-low hex font, bit0 = a ... bit6 = g
   localparam logic [6:0] FONT_0 = 7'h40;
   localparam logic [6:0] FONT_1 = 7'h79;
   localparam logic [6:0] FONT_2 = 7'h24;
   localparam logic [6:0] FONT_3 = 7'h30;
   localparam logic [6:0] FONT_4 = 7'h19;
   localparam logic [6:0] FONT_5 = 7'h12;
   localparam logic [6:0] FONT_6 = 7'h02;
   localparam logic [6:0] FONT_7 = 7'h78;
   localparam logic [6:0] FONT_8 = 7'h00;
   localparam logic [6:0] FONT_9 = 7'h10;
   localparam logic [6:0] FONT_A = 7'h08;
   localparam logic [6:0] FONT_B = 7'h03;
   localparam logic [6:0] FONT_C = 7'h46;
   localparam logic [6:0] FONT_D = 7'h21;
   localparam logic [6:0] FONT_E = 7'h06;
   localparam logic [6:0] FONT_F = 7'h0E;

   // All segments dark
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_inv.sv
// rtl/seg7_inv.sv - combinational segment pattern to nibble lookup with hit and blank flags
module seg7_inv
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output logic       hit_o,
   output logic       blank_o
);

   // Reverse font lookup; unknown patterns report no hit and a zero nibble
   always_comb begin
      nibble_o = 4'h0;
      hit_o    = 1'b1;
      blank_o  = 1'b0;
      case (seg_i)
         FONT_0:    nibble_o = 4'h0;
         FONT_1:    nibble_o = 4'h1;
         FONT_2:    nibble_o = 4'h2;
         FONT_3:    nibble_o = 4'h3;
         FONT_4:    nibble_o = 4'h4;
         FONT_5:    nibble_o = 4'h5;
         FONT_6:    nibble_o = 4'h6;
         FONT_7:    nibble_o = 4'h7;
         FONT_8:    nibble_o = 4'h8;
         FONT_9:    nibble_o = 4'h9;
         FONT_A:    nibble_o = 4'hA;
         FONT_B:    nibble_o = 4'hB;
         FONT_C:    nibble_o = 4'hC;
         FONT_D:    nibble_o = 4'hD;
         FONT_E:    nibble_o = 4'hE;
         FONT_F:    nibble_o = 4'hF;
         SEG_BLANK: begin
            hit_o   = 1'b0;
            blank_o = 1'b1;
         end
         default:   hit_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced capture and decode of a scanned 4-digit 7-seg display; SEG7_DP_EN adds decimal point capture
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [6:0]  seg_i,
   input  logic [3:0]  dig_i,
`ifdef SEG7_DP_EN
   input  logic        dp_i,
   output logic [3:0]  dp_o,
`endif
   output logic [15:0] hex_o,
   output logic [3:0]  valid_o,
   output logic [3:0]  blank_o,
   output logic        update_o,
   output logic        err_o
);

   localparam logic [3:0] STABLE_LIM = STABLE_CNT[3:0];

   logic [6:0]  seg_q;
   logic [3:0]  dig_q;
   logic [6:0]  ref_seg;
   logic [3:0]  ref_dig;
   logic [3:0]  count_q;
   logic [3:0]  count_d;
   logic [3:0]  cnt_inc;
   state_t      state_q;
   state_t      state_d;
   logic        ref_load;
   logic        accept;
   logic        same;
   logic        sel_valid;
   logic [1:0]  sel_idx;
   logic [3:0]  inv_nibble;
   logic        inv_hit;
   logic        inv_blank;
   logic [15:0] hex_d;
   logic [3:0]  valid_d;
   logic [3:0]  blank_d;
   logic        err_d;
   logic        changed;

`ifdef SEG7_DP_EN
   logic        dp_q;
   logic        ref_dp;
   logic [3:0]  dp_d;

   // Decimal point sample and reference ride alongside the segment sample
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dp_q   <= 1'b1;
         ref_dp <= 1'b0;
      end else begin
         dp_q <= dp_i;
         if (ref_load) ref_dp <= dp_q;
      end
   end

   assign same = (seg_q == ref_seg) && (dig_q == ref_dig) && (dp_q == ref_dp);
`else
   assign same = (seg_q == ref_seg) && (dig_q == ref_dig);
`endif

   // Single input register stage; everything downstream sees only this sample
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         seg_q <= SEG_BLANK;
         dig_q <= 4'hF;
      end else begin
         seg_q <= seg_i;
         dig_q <= dig_i;
      end
   end

   // Exactly one digit enable low selects a digit; anything else is a scan gap
   always_comb begin
      sel_valid = 1'b1;
      sel_idx   = 2'd0;
      case (dig_q)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: sel_valid = 1'b0;
      endcase
   end

   assign cnt_inc = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;

   seg7_inv u_inv (
      .seg_i    (seg_q),
      .nibble_o (inv_nibble),
      .hit_o    (inv_hit),
      .blank_o  (inv_blank)
   );

   // State, stability count and reference sample registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         ref_seg <= 7'd0;
         ref_dig <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (ref_load) begin
            ref_seg <= seg_q;
            ref_dig <= dig_q;
         end
      end
   end

   // Next state: accept fires on the same edge the count reaches the limit
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ref_load = 1'b0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d  = TRACK;
               count_d  = 4'd1;
               ref_load = 1'b1;
            end else begin
               count_d = 4'd0;
            end
         end
         TRACK: begin
            if (!sel_valid) begin
               state_d = IDLE;
               count_d = 4'd0;
            end else if (same) begin
               count_d = cnt_inc;
               if (cnt_inc == STABLE_LIM) begin
                  state_d = LOCKED;
                  accept  = 1'b1;
               end
            end else begin
               count_d  = 4'd1;
               ref_load = 1'b1;
            end
         end
         LOCKED: begin
            if (!sel_valid) begin
               state_d = IDLE;
               count_d = 4'd0;
            end else if (!same) begin
               state_d  = TRACK;
               count_d  = 4'd1;
               ref_load = 1'b1;
            end else begin
               count_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 4'd0;
         end
      endcase
   end

   // Per-digit result of an accept; unchanged stored state means no update pulse
   always_comb begin
      hex_d   = hex_o;
      valid_d = valid_o;
      blank_d = blank_o;
      err_d   = 1'b0;
`ifdef SEG7_DP_EN
      dp_d    = dp_o;
`endif
      if (accept) begin
`ifdef SEG7_DP_EN
         dp_d[sel_idx] = dp_q;
`endif
         if (inv_hit) begin
            hex_d[{sel_idx, 2'b00} +: 4] = inv_nibble;
            valid_d[sel_idx]             = 1'b1;
            blank_d[sel_idx]             = 1'b0;
         end else if (inv_blank) begin
            valid_d[sel_idx] = 1'b0;
            blank_d[sel_idx] = 1'b1;
         end else begin
            valid_d[sel_idx] = 1'b0;
            blank_d[sel_idx] = 1'b0;
            err_d            = 1'b1;
         end
      end
`ifdef SEG7_DP_EN
      changed = (hex_d != hex_o) || (valid_d != valid_o) || (blank_d != blank_o) || (dp_d != dp_o);
`else
      changed = (hex_d != hex_o) || (valid_d != valid_o) || (blank_d != blank_o);
`endif
   end

   // Stored digit state and single-cycle status pulses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hex_o    <= 16'h0000;
         valid_o  <= 4'h0;
         blank_o  <= 4'h0;
         update_o <= 1'b0;
         err_o    <= 1'b0;
`ifdef SEG7_DP_EN
         dp_o     <= 4'h0;
`endif
      end else begin
         hex_o    <= hex_d;
         valid_o  <= valid_d;
         blank_o  <= blank_d;
         update_o <= accept && changed;
         err_o    <= err_d;
`ifdef SEG7_DP_EN
         dp_o     <= dp_d;
`endif
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder with directed vectors
module tb_seg7_scan_decoder;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [6:0]  seg_i;
   logic [3:0]  dig_i;
   logic [15:0] hex_o;
   logic [3:0]  valid_o;
   logic [3:0]  blank_o;
   logic        update_o;
   logic        err_o;

   typedef struct {
      int          cyc;
      logic [15:0] hex;
      logic [3:0]  valid;
      logic [3:0]  blank;
      logic        upd;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   cycle  = 0;
   int   checks = 0;
   int   errors = 0;

   logic [6:0]  font [16];
   logic [15:0] exp_hex;

   seg7_scan_decoder #(.STABLE_CNT(4)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .seg_i    (seg_i),
      .dig_i    (dig_i),
      .hex_o    (hex_o),
      .valid_o  (valid_o),
      .blank_o  (blank_o),
      .update_o (update_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic push(input int cyc, input logic [15:0] hex, input logic [3:0] valid,
                       input logic [3:0] blank, input logic upd, input logic err);
      exp_t e;
      e.cyc = cyc; e.hex = hex; e.valid = valid; e.blank = blank; e.upd = upd; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Monitor: every update/err pulse must match the oldest expectation, on its cycle
   always @(negedge clk_i) begin
      exp_t e;
      if (update_o || err_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, update_o, err_o}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("accept_cycle", cycle, e.cyc);
            chk("hex", {16'd0, hex_o}, {16'd0, e.hex});
            chk("valid", {28'd0, valid_o}, {28'd0, e.valid});
            chk("blank", {28'd0, blank_o}, {28'd0, e.blank});
            chk("upd_err", {30'd0, update_o, err_o}, {30'd0, e.upd, e.err});
         end
      end else if (exp_q.size() != 0 && cycle > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         chk("missing_pulse_at", cycle, e.cyc);
      end
   end

   initial begin
      font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
      font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
      font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
      font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;

      rst_n_i = 1'b0;
      seg_i   = 7'h7F;
      dig_i   = 4'hF;
      wait_cyc(3);
      chk("rst_hex", {16'd0, hex_o}, 32'd0);
      chk("rst_valid", {28'd0, valid_o}, 32'd0);
      chk("rst_blank", {28'd0, blank_o}, 32'd0);
      chk("rst_update", {31'd0, update_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      rst_n_i = 1'b1;

      // Digit 0 shows "2"; then held long after with no further update
      dig_i = 4'hE; seg_i = 7'h24;
      push(cycle + 5, 16'h0002, 4'b0001, 4'b0000, 1'b1, 1'b0);
      wait_cyc(25);

      // Digit 2 unknown pattern: err only, nothing stored changes
      dig_i = 4'hB; seg_i = 7'h55;
      push(cycle + 5, 16'h0002, 4'b0001, 4'b0000, 1'b0, 1'b1);
      wait_cyc(8);

      // Digit 3 flicker never settles, then blank settles
      dig_i = 4'h7;
      for (int i = 0; i < 8; i++) begin
         seg_i = (i % 2 == 0) ? 7'h40 : 7'h79;
         wait_cyc(2);
      end
      seg_i = 7'h7F;
      push(cycle + 5, 16'h0002, 4'b0001, 4'b1000, 1'b1, 1'b0);
      wait_cyc(8);

      // Two digits selected: stays idle, nothing changes
      dig_i = 4'hC; seg_i = 7'h00;
      wait_cyc(10);
      chk("idle_hex", {16'd0, hex_o}, 32'h0002);
      chk("idle_valid", {28'd0, valid_o}, 32'h1);
      chk("idle_blank", {28'd0, blank_o}, 32'h8);

      // Every font glyph on digit 1
      exp_hex = 16'h0002;
      dig_i = 4'hD;
      for (int i = 0; i < 16; i++) begin
         seg_i = font[i];
         exp_hex[7:4] = 4'(i);
         push(cycle + 5, exp_hex, 4'b0011, 4'b1000, 1'b1, 1'b0);
         wait_cyc(6);
      end

      // Reset after 3 matching samples, then a full fresh count is needed
      dig_i = 4'hE; seg_i = 7'h79;
      wait_cyc(4);
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_hex", {16'd0, hex_o}, 32'd0);
      chk("mid_rst_valid", {28'd0, valid_o}, 32'd0);
      chk("mid_rst_blank", {28'd0, blank_o}, 32'd0);
      chk("mid_rst_update", {31'd0, update_o}, 32'd0);
      chk("mid_rst_err", {31'd0, err_o}, 32'd0);
      rst_n_i = 1'b1;
      push(cycle + 5, 16'h0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
      wait_cyc(12);

      chk("pending_expectations", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 4, SHALL set the consecutive identical samples required to accept a digit (range 2..15).
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 seg_i  in  7  segment lines, active-low (0 = lit), bit0 = a ... bit6 = g.
REQ-005 dig_i  in  4  digit enables, active-low, one-hot-low when valid.
REQ-006 hex_o  out  16  decoded nibbles, digit n at [4n+3:4n].
REQ-007 valid_o  out  4  per digit: last accepted pattern decoded to a hex value.
REQ-008 blank_o  out  4  per digit: last accepted pattern was all-off (7'h7F).
REQ-009 update_o  out  1  one-cycle pulse when any digit's stored state changes.
REQ-010 err_o  out  1  one-cycle pulse when an unknown pattern is accepted.

Function
REQ-011 seg_i and dig_i SHALL be registered once; all decoding SHALL use the registered sample.
REQ-012 Decode table SHALL be the team's standard active-low hex font: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (7-bit hex).
REQ-013 FSM states: IDLE, TRACK, LOCKED.
REQ-014 IDLE: registered dig_i not exactly one bit low; count cleared; stored outputs held.
REQ-015 IDLE->TRACK when one digit is selected; count loads 1 and the (seg,dig) sample is latched as reference.
REQ-016 TRACK: sample equal to reference increments count; differing valid sample reloads reference, count=1; invalid dig_i -> IDLE.
REQ-017 TRACK->LOCKED at the edge where count reaches STABLE_CNT; the accept action (REQ-018..020) SHALL occur at that same edge.
REQ-018 Accept, known pattern: hex_o nibble = decoded value, valid_o[d]=1, blank_o[d]=0.
REQ-019 Accept, 7'h7F: valid_o[d]=0, blank_o[d]=1, nibble held.
REQ-020 Accept, other pattern: valid_o[d]=0, blank_o[d]=0, nibble held, err_o pulses.
REQ-021 update_o SHALL pulse on the accept edge only if nibble, valid_o[d] or blank_o[d] changed.
REQ-022 LOCKED: no further accept while sample equals reference; change -> TRACK with count=1; invalid dig_i -> IDLE.
REQ-023 Latency: input held stable from edge k is reflected on outputs at edge k+STABLE_CNT.
REQ-024 Count SHALL saturate and never wrap.

Reset
REQ-025 rst_n_i low SHALL immediately clear hex_o, valid_o, blank_o, update_o, err_o, count, reference, and force IDLE, including mid-TRACK.
REQ-026 First accept after reset SHALL require a full STABLE_CNT samples.

Configuration
REQ-027 With SEG7_DP_EN defined: extra input dp_i (1, active-low) joins the sample/reference compare, and output dp_o (4) stores the accepted dp per digit, reset 0, dp changes also trigger update_o.
REQ-028 Without SEG7_DP_EN: no dp_i/dp_o ports; behaviour as REQ-011..026.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16 font constants, SEG_BLANK (7'h7F), and the FSM state typedef.
REQ-030 Sub-module seg7_inv SHALL perform the combinational pattern->nibble lookup with hit and blank flags.

Verification
REQ-031 Reset, then dig_i=4'hE, seg_i=7'h24 held 4 cycles -> at edge k+4 hex_o[3:0]=2, valid_o=4'b0001, update_o pulses once.
REQ-032 Hold REQ-031 stimulus 20 more cycles -> no further update_o.
REQ-033 dig_i=4'hB, seg_i=7'h55 stable -> err_o pulse, valid_o[2]=0, hex_o[11:8] unchanged.
REQ-034 dig_i=4'h7, seg_i toggles 7'h40/7'h79 every 2 cycles -> no accept, no update_o; then 7'h7F stable -> blank_o[3]=1.
REQ-035 dig_i=4'hC (two digits) with 7'h00 for 10 cycles -> IDLE, outputs unchanged.
REQ-036 rst_n_i pulsed low after 3 matching samples -> outputs clear at once; after release, 4 fresh samples needed to accept.
